// File: rtl/chain_stim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain_stim_pkg : shared types for the delay-chain pulse stimulus     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package chain_stim_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_REP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] high;
    logic [DEF_CNT_W-1:0] low;
    logic [DEF_REP_W-1:0] rep;
  } desc_t;

endpackage
`default_nettype wire

// File: rtl/chain_desc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain_desc_fifo : synchronous descriptor queue with flush            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module chain_desc_fifo
  import chain_stim_pkg::*;
#(
  parameter int DW    = $bits(desc_t),
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    rdata = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/chain_pulse_stimulus.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain_pulse_stimulus : plays queued pulse descriptors on pulse_out   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module chain_pulse_stimulus
  import chain_stim_pkg::*;
#(
  parameter int   CNT_W      = DEF_CNT_W,
  parameter int   REP_W      = DEF_REP_W,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [CNT_W-1:0] desc_high,
  input  logic [CNT_W-1:0] desc_low,
  input  logic [REP_W-1:0] desc_rep,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pulse_out,
  output logic [15:0]      pulse_cnt
);

  localparam int DW = 2*CNT_W + REP_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [CNT_W-1:0] hm1_q, hm1_d;
  logic [CNT_W-1:0] lm1_q, lm1_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             pulse_out_q, pulse_out_d;
  logic             done_q, done_d;
  logic [15:0]      pulse_cnt_q, pulse_cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic [DW-1:0]    fifo_rdata;
  logic             load;

  // Zero-length phases play as one cycle; counters hold length-1.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign desc_ready = !fifo_full && !abort;
  assign fifo_push  = desc_valid && desc_ready;

  chain_desc_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (fifo_push),
    .wdata ({desc_high, desc_low, desc_rep}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    ph_cnt_d    = ph_cnt_q;
    hm1_d       = hm1_q;
    lm1_d       = lm1_q;
    rep_d       = rep_q;
    pulse_out_d = pulse_out_q;
    done_d      = 1'b0;
    pulse_cnt_d = pulse_cnt_q;
    fifo_pop    = 1'b0;
    load        = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      pulse_out_d = IDLE_LEVEL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !fifo_empty) begin
            load        = 1'b1;
            pulse_cnt_d = 16'd1;
          end
        end
        ST_HIGH: begin
          if (ph_cnt_q == '0) begin
            state_d     = ST_LOW;
            ph_cnt_d    = lm1_q;
            pulse_out_d = IDLE_LEVEL;
          end else begin
            ph_cnt_d = ph_cnt_q - CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (ph_cnt_q != '0) begin
            ph_cnt_d = ph_cnt_q - CNT_W'(1);
          end else if (rep_q != '0) begin
            rep_d       = rep_q - REP_W'(1);
            state_d     = ST_HIGH;
            ph_cnt_d    = hm1_q;
            pulse_out_d = ~IDLE_LEVEL;
            pulse_cnt_d = pulse_cnt_q + 16'd1;
          end else if (!fifo_empty) begin
            load        = 1'b1;
            pulse_cnt_d = pulse_cnt_q + 16'd1;
          end else begin
            state_d     = ST_IDLE;
            pulse_out_d = IDLE_LEVEL;
            done_d      = 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          pulse_out_d = IDLE_LEVEL;
        end
      endcase

      // Chaining into the next descriptor shares the start path: no gap cycle.
      if (load) begin
        fifo_pop    = 1'b1;
        hm1_d       = len_m1(fifo_rdata[DW-1 -: CNT_W]);
        lm1_d       = len_m1(fifo_rdata[REP_W +: CNT_W]);
        rep_d       = fifo_rdata[REP_W-1:0];
        ph_cnt_d    = len_m1(fifo_rdata[DW-1 -: CNT_W]);
        state_d     = ST_HIGH;
        pulse_out_d = ~IDLE_LEVEL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ph_cnt_q    <= '0;
      hm1_q       <= '0;
      lm1_q       <= '0;
      rep_q       <= '0;
      pulse_out_q <= IDLE_LEVEL;
      done_q      <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      hm1_q       <= hm1_d;
      lm1_q       <= lm1_d;
      rep_q       <= rep_d;
      pulse_out_q <= pulse_out_d;
      done_q      <= done_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pulse_out = pulse_out_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_chain_pulse_stimulus.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chain_pulse_stimulus : directed bench for chain_pulse_stimulus    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_chain_pulse_stimulus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_high;
  logic [15:0] desc_low;
  logic [7:0]  desc_rep;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        pulse_out;
  logic [15:0] pulse_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chain_pulse_stimulus dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_high  (desc_high),
    .desc_low   (desc_low),
    .desc_rep   (desc_rep),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .pulse_out  (pulse_out),
    .pulse_cnt  (pulse_cnt)
  );

  // wave is written in time order: leftmost of the len bits is the first sample.
  typedef struct {
    int          h0, l0, r0;
    int          h1, l1, r1;
    int          n;
    logic [63:0] wave;
    int          len;
    int          cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int h, input int l, input int r);
    @(negedge clk);
    desc_valid = 1'b1;
    desc_high  = 16'(h);
    desc_low   = 16'(l);
    desc_rep   = 8'(r);
    check("push_ready", {31'd0, desc_ready}, 32'd1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, 2, 0, 0, 0, 0, 1, 64'b11100,          5, 1};
    vecs[1] = '{0, 0, 3, 0, 0, 0, 1, 64'b10101010,       8, 4};
    vecs[2] = '{2, 1, 0, 1, 4, 1, 2, 64'b1101000010000, 13, 3};
    vecs[3] = '{4, 0, 1, 0, 0, 0, 1, 64'b1111011110,    10, 2};
    vecs[4] = '{0, 3, 0, 2, 0, 0, 2, 64'b1000110,        7, 2};

    rst_n = 1'b0; desc_valid = 1'b0; desc_high = '0; desc_low = '0;
    desc_rep = '0; start = 1'b0; abort = 1'b0;
    #1;
    check("rst_pulse_out", {31'd0, pulse_out}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_pulse_cnt", {16'd0, pulse_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, desc_ready}, 32'd1);

    // Table-driven waveform cases.
    for (int c = 0; c < 5; c++) begin
      push(vecs[c].h0, vecs[c].l0, vecs[c].r0);
      if (vecs[c].n == 2) push(vecs[c].h1, vecs[c].l1, vecs[c].r1);
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < vecs[c].len; i++) begin
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("wave_c%0d_s%0d", c, i), {31'd0, pulse_out},
              {31'd0, vecs[c].wave[vecs[c].len-1-i]});
        check($sformatf("busy_c%0d_s%0d", c, i), {31'd0, busy}, 32'd1);
        check($sformatf("nodone_c%0d_s%0d", c, i), {31'd0, done}, 32'd0);
      end
      @(posedge clk); #1;
      check($sformatf("done_c%0d", c), {31'd0, done}, 32'd1);
      check($sformatf("idle_c%0d", c), {31'd0, busy}, 32'd0);
      check($sformatf("idle_lvl_c%0d", c), {31'd0, pulse_out}, 32'd0);
      check($sformatf("cnt_c%0d", c), {16'd0, pulse_cnt}, vecs[c].cnt);
      @(posedge clk); #1;
      check($sformatf("done_once_c%0d", c), {31'd0, done}, 32'd0);
    end

    // Start with an empty queue is ignored.
    pulse_start();
    check("empty_start_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("empty_start_done", {31'd0, done}, 32'd0);
    check("empty_start_cnt",  {16'd0, pulse_cnt}, 32'd2);

    // Abort and start together: abort wins and flushes the queue.
    push(1, 1, 0);
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(posedge clk); #1; abort = 1'b0; start = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    check("abort_flushed_busy", {31'd0, busy}, 32'd0);

    // Full queue holds off the fifth descriptor until a pop frees a slot.
    for (int i = 0; i < 4; i++) push(1, 1, 0);
    @(negedge clk);
    desc_valid = 1'b1; desc_high = 16'd1; desc_low = 16'd1; desc_rep = 8'd0;
    start = 1'b1;
    #1;
    check("full_ready", {31'd0, desc_ready}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("pop_frees_ready", {31'd0, desc_ready}, 32'd1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    check("refull_ready", {31'd0, desc_ready}, 32'd0);
    wait_done(60);
    check("full_cnt", {16'd0, pulse_cnt}, 32'd5);

    // Abort mid-HIGH drops the queue and the descriptor offered alongside it.
    push(10, 10, 5);
    push(1, 1, 0);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_high", {31'd0, pulse_out}, 32'd1);
    abort = 1'b1; desc_valid = 1'b1; desc_high = 16'd2; desc_low = 16'd2;
    #1;
    check("abort_ready", {31'd0, desc_ready}, 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; desc_valid = 1'b0;
    check("abort_pulse_out", {31'd0, pulse_out}, 32'd0);
    check("abort_busy",      {31'd0, busy},      32'd0);
    check("abort_done",      {31'd0, done},      32'd0);
    check("abort_cnt",       {16'd0, pulse_cnt}, 32'd1);
    pulse_start();
    check("post_abort_start", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("post_abort_done", {31'd0, done}, 32'd0);

    // Asynchronous reset in the LOW phase clears immediately.
    push(2, 5, 0);
    pulse_start();
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_pulse_out", {31'd0, pulse_out}, 32'd0);
    check("arst_busy",      {31'd0, busy},      32'd0);
    check("arst_cnt",       {16'd0, pulse_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_ready", {31'd0, desc_ready}, 32'd1);
    check("arst_idle",  {31'd0, busy},       32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chain_pulse_stimulus.md
Name: chain_pulse_stimulus

Overview:
- Upstream stimulus source for the NOR/INV delay-chain evaluation blocks.
- Plays queued pulse descriptors (high length, low length, repeat count) as a clocked single-bit waveform on pulse_out, which drives the chain input.
- Pulse widths are exact and repeatable, so chain delay and pulse degradation are characterised against a known input.
- Host loads descriptors via valid/ready, then issues start; abort kills playback at any time.

Parameters:
- CNT_W, 16, width of the high/low length fields in clock cycles.
- REP_W, 8, width of the repeat field.
- FIFO_DEPTH, 4, descriptor queue depth; power of two, >= 2.
- IDLE_LEVEL, 1'b0, pulse_out level while not playing.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor accepted when valid and ready are both high.
- desc_high  in  CNT_W  cycles pulse_out is at the active level (!IDLE_LEVEL).
- desc_low  in  CNT_W  cycles pulse_out is at IDLE_LEVEL after each high phase.
- desc_rep  in  REP_W  extra repetitions; the pulse is played desc_rep+1 times.
- start  in  1  single-cycle playback request.
- abort  in  1  single-cycle stop-and-flush.
- busy  out  1  high while the FSM is not in IDLE.
- done  out  1  one-cycle pulse when playback completes normally.
- pulse_out  out  1  registered stimulus to the chain input.
- pulse_cnt  out  16  active phases emitted since the last accepted start; wraps at 2^16.

Behaviour:
- Reset (asynchronous, active-low):
  - FIFO empty; FSM in IDLE.
  - pulse_out=IDLE_LEVEL, busy=0, done=0, pulse_cnt=0.
  - desc_ready=1 once rst_n deasserts.
- Queue:
  - desc_ready = !full && !abort.
  - A push while full is never accepted, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: both take effect.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - start=1 with FIFO non-empty: pop the head descriptor into working registers; clear pulse_cnt; go to HIGH. On the next edge pulse_out=!IDLE_LEVEL and pulse_cnt=1 (latency: one cycle after start is sampled).
  - start=1 with FIFO empty: ignored. No done pulse, pulse_cnt unchanged.
  - start while busy: ignored.
- HIGH:
  - Stay for L_h = max(desc_high,1) cycles, then go to LOW.
  - pulse_out=IDLE_LEVEL from the cycle after the last high cycle.
- LOW:
  - Stay for L_l = max(desc_low,1) cycles. A length of 0 is treated as 1 for both phases.
  - At the end of LOW, in priority order:
    - Repeats remaining: decrement the repeat counter, go to HIGH, pulse_cnt+1.
    - Otherwise, FIFO non-empty: pop the next descriptor, go to HIGH, pulse_cnt+1. No idle gap between descriptors.
    - Otherwise: go to IDLE and assert done for exactly one cycle, coincident with the first IDLE cycle.
- Waveform period per pulse is exactly L_h+L_l cycles.
- abort (highest priority, any state):
  - Next edge: FSM in IDLE, pulse_out=IDLE_LEVEL, FIFO flushed, done=0, pulse_cnt held.
  - A desc_valid offered in the abort cycle is dropped (desc_ready=0).
- abort and start in the same cycle: abort wins.
- rst_n asserted mid-playback: immediate return to reset values, with no glitch beyond the asynchronous clear.
- Down-counters are CNT_W bits, load L-1 and terminate at 0. No overflow is possible.
- pulse_cnt is saturation-free and wraps modulo 2^16.

Decomposition:
- Shared package chain_stim_pkg holds:
  - State enum (IDLE, HIGH, LOW).
  - Descriptor struct {high, low, rep}.
  - CNT_W and REP_W defaults.
- One sub-module, chain_desc_fifo: synchronous FIFO of descriptor structs with push, pop, full, empty and flush, and asynchronous active-low reset.
- FSM, phase counters and output register live in chain_pulse_stimulus.

Test Plan:
- Single pulse: push {high=3, low=2, rep=0}, start -> pulse_out high for exactly 3 cycles starting 1 cycle after start, low for 2; done pulses once 6 cycles after start; pulse_cnt=1.
- Repeats and zero lengths: push {0,0,rep=3}, start -> 4 alternating 1-cycle high / 1-cycle low pulses; pulse_cnt=4; done once.
- Back-to-back descriptors: push {2,1,0} and {1,4,1}, start -> waveform H2 L1 H1 L4 H1 L4 with no gap between descriptors; pulse_cnt=3.
- Full queue: push until desc_ready=0 with FIFO_DEPTH=4 -> 5th descriptor held off; during playback, a pop frees one slot and the held descriptor is accepted the following cycle.
- Abort mid-HIGH: {10,10,5} playing, assert abort at cycle 4 -> next edge pulse_out=IDLE_LEVEL, busy=0, no done, FIFO empty; a subsequent start with empty FIFO is ignored.
- Async reset mid-LOW: drop rst_n without a clock edge -> pulse_out=IDLE_LEVEL and busy=0 immediately; pulse_cnt=0.
